// File: rtl/mem_pkg.sv
// Shared memory-port types: write-type encoding and requester indices.
package mem_pkg;

   typedef enum logic [1:0] {
      WR_NONE = 2'b00,
      WR_B    = 2'b01,
      WR_H    = 2'b10,
      WR_W    = 2'b11
   } wr_type_t;

   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_DM = 1'b1
   } req_idx_t;

   function automatic logic is_read(input logic [1:0] wr_type);
      return wr_type_t'(wr_type) == WR_NONE;
   endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store; data wins
// by default, and a bounded starvation counter forces a fetch grant.
module mem_port_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 3,
   parameter int unsigned AW           = 32,
   parameter int unsigned DW           = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_if_req,
   input  logic [AW-1:0] i_if_addr,
   output logic          o_if_gnt,
   output logic          o_if_rvalid,
   output logic [DW-1:0] o_if_rdata,
   input  logic          i_dm_req,
   input  logic [AW-1:0] i_dm_addr,
   input  logic [1:0]    i_dm_wr_type,
   input  logic [DW-1:0] i_dm_wdata,
   output logic          o_dm_gnt,
   output logic          o_dm_rvalid,
   output logic [DW-1:0] o_dm_rdata,
   output logic          o_mem_en,
   output logic [AW-1:0] o_mem_addr,
   output logic [1:0]    o_mem_wr_type,
   output logic [DW-1:0] o_mem_wdata,
   input  logic [DW-1:0] i_mem_rdata,
   output logic [31:0]   o_conflict_cnt
);

   localparam int unsigned   SW         = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   logic [SW-1:0] starve_q, starve_d;
   logic          rsp_if_q, rsp_if_d;
   logic          rsp_dm_q, rsp_dm_d;
   logic [31:0]   conflict_q, conflict_d;

   logic          both_req;
   req_idx_t      gnt_sel;

   assign both_req = i_if_req & i_dm_req;

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      o_if_gnt = 1'b0;
      o_dm_gnt = 1'b0;
      if (!rst) begin
         if (both_req) begin
            if (starve_q == STARVE_MAX) o_if_gnt = 1'b1;
            else                        o_dm_gnt = 1'b1;
         end else begin
            o_if_gnt = i_if_req;
            o_dm_gnt = i_dm_req;
         end
      end
      gnt_sel = o_if_gnt ? REQ_IF : REQ_DM;
   end

   // Memory drive depends only on grants and requester inputs, never on read data.
   always_comb begin
      o_mem_en      = o_if_gnt | o_dm_gnt;
      o_mem_addr    = '0;
      o_mem_wr_type = WR_NONE;
      o_mem_wdata   = '0;
      if (o_mem_en) begin
         unique case (gnt_sel)
            REQ_IF: o_mem_addr = i_if_addr;
            REQ_DM: begin
               o_mem_addr    = i_dm_addr;
               o_mem_wr_type = i_dm_wr_type;
               o_mem_wdata   = i_dm_wdata;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      starve_d = starve_q;
      if (o_if_gnt)                                starve_d = '0;
      else if (i_if_req && starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;

      rsp_if_d = o_if_gnt;
      rsp_dm_d = o_dm_gnt & is_read(i_dm_wr_type);

      conflict_d = conflict_q;
      if (both_req && conflict_q != '1) conflict_d = conflict_q + 32'd1;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q   <= '0;
         rsp_if_q   <= 1'b0;
         rsp_dm_q   <= 1'b0;
         conflict_q <= '0;
      end else begin
         starve_q   <= starve_d;
         rsp_if_q   <= rsp_if_d;
         rsp_dm_q   <= rsp_dm_d;
         conflict_q <= conflict_d;
      end
   end

   // Reset masks the response flops so a grant just before reset yields nothing.
   always_comb begin
      o_if_rvalid    = rsp_if_q & ~rst;
      o_dm_rvalid    = rsp_dm_q & ~rst;
      o_if_rdata     = o_if_rvalid ? i_mem_rdata : '0;
      o_dm_rdata     = o_dm_rvalid ? i_mem_rdata : '0;
      o_conflict_cnt = rst ? 32'd0 : conflict_q;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus a response scoreboard.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_if_req;
   logic [31:0] i_if_addr;
   logic        o_if_gnt;
   logic        o_if_rvalid;
   logic [31:0] o_if_rdata;
   logic        i_dm_req;
   logic [31:0] i_dm_addr;
   logic [1:0]  i_dm_wr_type;
   logic [31:0] i_dm_wdata;
   logic        o_dm_gnt;
   logic        o_dm_rvalid;
   logic [31:0] o_dm_rdata;
   logic        o_mem_en;
   logic [31:0] o_mem_addr;
   logic [1:0]  o_mem_wr_type;
   logic [31:0] o_mem_wdata;
   logic [31:0] i_mem_rdata;
   logic [31:0] o_conflict_cnt;

   mem_port_arbiter #(.STARVE_LIMIT(3), .AW(32), .DW(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_if_req       (i_if_req),
      .i_if_addr      (i_if_addr),
      .o_if_gnt       (o_if_gnt),
      .o_if_rvalid    (o_if_rvalid),
      .o_if_rdata     (o_if_rdata),
      .i_dm_req       (i_dm_req),
      .i_dm_addr      (i_dm_addr),
      .i_dm_wr_type   (i_dm_wr_type),
      .i_dm_wdata     (i_dm_wdata),
      .o_dm_gnt       (o_dm_gnt),
      .o_dm_rvalid    (o_dm_rvalid),
      .o_dm_rdata     (o_dm_rdata),
      .o_mem_en       (o_mem_en),
      .o_mem_addr     (o_mem_addr),
      .o_mem_wr_type  (o_mem_wr_type),
      .o_mem_wdata    (o_mem_wdata),
      .i_mem_rdata    (i_mem_rdata),
      .o_conflict_cnt (o_conflict_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        if_req;
      logic [31:0] if_addr;
      logic        dm_req;
      logic [31:0] dm_addr;
      logic [1:0]  dm_wr;
      logic [31:0] dm_wdata;
      logic        e_if;
      logic        e_dm;
   } vec_t;

   typedef struct packed {
      logic        is_dm;
      logic [31:0] data;
   } rsp_t;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   logic [31:0] exp_conf = 0;
   rsp_t        rsp_q[$];
   logic [31:0] mem_stub   [logic [31:0]];
   logic [31:0] shadow_mem [logic [31:0]];
   vec_t        tbl[22];

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a & 32'hFFFF_FFFC) * 32'h9E37_79B1 + 32'h1234_5678;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [1:0] wr, input logic [1:0] lo);
      logic [31:0] r;
      r = old;
      case (wr)
         2'b01:   r[lo*8 +: 8]     = wd[lo*8 +: 8];
         2'b10:   r[lo[1]*16 +: 16] = wd[lo[1]*16 +: 16];
         2'b11:   r = wd;
         default: r = old;
      endcase
      return r;
   endfunction

   function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                               input logic [31:0] da, input logic [1:0] dw,
                               input logic [31:0] wd, input logic ei, input logic ed);
      vec_t v;
      v.if_req = ir; v.if_addr = ia; v.dm_req = dr; v.dm_addr = da;
      v.dm_wr = dw; v.dm_wdata = wd; v.e_if = ei; v.e_dm = ed;
      return v;
   endfunction

   // Memory macro stand-in: one-cycle read latency, junk on the read bus otherwise.
   always @(posedge clk) begin
      logic [31:0] w, cur;
      if (o_mem_en) begin
         w   = {o_mem_addr[31:2], 2'b00};
         cur = mem_stub.exists(w) ? mem_stub[w] : init_word(w);
         if (o_mem_wr_type == 2'b00) i_mem_rdata <= cur;
         else begin
            mem_stub[w] = merge(cur, o_mem_wdata, o_mem_wr_type, o_mem_addr[1:0]);
            i_mem_rdata <= $urandom();
         end
      end else begin
         i_mem_rdata <= $urandom();
      end
   end

   function automatic logic [31:0] shadow_rd(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      return shadow_mem.exists(w) ? shadow_mem[w] : init_word(w);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic run_cycle(input logic rst_v, input vec_t v);
      rsp_t        e;
      logic [31:0] w;
      rst          = rst_v;
      i_if_req     = v.if_req;
      i_if_addr    = v.if_addr;
      i_dm_req     = v.dm_req;
      i_dm_addr    = v.dm_addr;
      i_dm_wr_type = v.dm_wr;
      i_dm_wdata   = v.dm_wdata;
      @(negedge clk);

      if (rst_v || rsp_q.size() == 0) begin
         check("if_rvalid", {31'b0, o_if_rvalid}, 32'd0);
         check("dm_rvalid", {31'b0, o_dm_rvalid}, 32'd0);
         check("if_rdata", o_if_rdata, 32'd0);
         check("dm_rdata", o_dm_rdata, 32'd0);
         rsp_q.delete();
      end else begin
         e = rsp_q.pop_front();
         check("if_rvalid", {31'b0, o_if_rvalid}, {31'b0, !e.is_dm});
         check("dm_rvalid", {31'b0, o_dm_rvalid}, {31'b0, e.is_dm});
         check("if_rdata", o_if_rdata, e.is_dm ? 32'd0 : e.data);
         check("dm_rdata", o_dm_rdata, e.is_dm ? e.data : 32'd0);
      end

      check("if_gnt", {31'b0, o_if_gnt}, {31'b0, v.e_if});
      check("dm_gnt", {31'b0, o_dm_gnt}, {31'b0, v.e_dm});
      check("mem_en", {31'b0, o_mem_en}, {31'b0, v.e_if | v.e_dm});
      check("mem_addr", o_mem_addr, v.e_if ? v.if_addr : v.e_dm ? v.dm_addr : 32'd0);
      check("mem_wr_type", {30'b0, o_mem_wr_type}, {30'b0, v.e_dm ? v.dm_wr : 2'b00});
      check("mem_wdata", o_mem_wdata, v.e_dm ? v.dm_wdata : 32'd0);
      check("conflict_cnt", o_conflict_cnt, rst_v ? 32'd0 : exp_conf);

      if (v.e_if) rsp_q.push_back('{is_dm: 1'b0, data: shadow_rd(v.if_addr)});
      if (v.e_dm) begin
         if (v.dm_wr == 2'b00) rsp_q.push_back('{is_dm: 1'b1, data: shadow_rd(v.dm_addr)});
         else begin
            w = {v.dm_addr[31:2], 2'b00};
            shadow_mem[w] = merge(shadow_rd(w), v.dm_wdata, v.dm_wr, v.dm_addr[1:0]);
         end
      end
      if (rst_v) exp_conf = 0;
      else if (v.if_req && v.dm_req) exp_conf++;

      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vec_t idle;
      idle = mk(0, 0, 0, 0, 2'b00, 0, 0, 0);

      tbl[0]  = idle;
      // Fetch-only stream
      tbl[1]  = mk(1, 32'h0, 0, 0, 2'b00, 0, 1, 0);
      tbl[2]  = mk(1, 32'h4, 0, 0, 2'b00, 0, 1, 0);
      tbl[3]  = mk(1, 32'h8, 0, 0, 2'b00, 0, 1, 0);
      // Both requesting: DM, DM, DM, IF repeating
      for (int i = 0; i < 8; i++)
         tbl[4+i] = mk(1, 32'h1000 + 32'(i*4), 1, 32'h2000 + 32'(i*4), 2'b00,
                       32'hA000_0000 + 32'(i), (i % 4) == 3, (i % 4) != 3);
      // Word write then read back
      tbl[12] = mk(0, 0, 1, 32'h100, 2'b11, 32'hDEAD_BEEF, 0, 1);
      tbl[13] = mk(0, 0, 1, 32'h100, 2'b00, 32'h0, 0, 1);
      tbl[14] = mk(1, 32'h40, 0, 0, 2'b00, 0, 1, 0);
      // Fetch loses twice, drops out (counter holds), returns and is granted after one more loss
      tbl[15] = mk(1, 32'h80, 1, 32'h200, 2'b00, 32'h0, 0, 1);
      tbl[16] = mk(1, 32'h80, 1, 32'h204, 2'b00, 32'h0, 0, 1);
      tbl[17] = mk(0, 32'h0, 1, 32'h301, 2'b01, 32'h1122_3344, 0, 1);
      tbl[18] = mk(0, 32'h0, 1, 32'h302, 2'b10, 32'h5566_7788, 0, 1);
      tbl[19] = mk(1, 32'h84, 1, 32'h300, 2'b00, 32'h0, 0, 1);
      tbl[20] = mk(1, 32'h84, 1, 32'h308, 2'b00, 32'h0, 1, 0);
      tbl[21] = idle;

      rst = 1'b1;
      i_if_req = 0; i_if_addr = 0; i_dm_req = 0; i_dm_addr = 0;
      i_dm_wr_type = 0; i_dm_wdata = 0;
      @(posedge clk);
      #1;
      run_cycle(1, mk(1, 32'h10, 1, 32'h20, 2'b00, 0, 0, 0));
      run_cycle(1, idle);

      for (int i = 0; i < 22; i++) run_cycle(0, tbl[i]);

      // Reset the cycle after a data-read grant: no rvalid, counters clear
      run_cycle(0, mk(1, 32'h500, 1, 32'h600, 2'b00, 0, 0, 1));
      run_cycle(1, mk(1, 32'h500, 1, 32'h604, 2'b00, 0, 0, 0));
      for (int i = 0; i < 4; i++)
         run_cycle(0, mk(1, 32'h500, 1, 32'h700 + 32'(i*4), 2'b00, 0, i == 3, i != 3));
      run_cycle(0, idle);
      run_cycle(0, idle);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single memory port of the core's unified instruction/data memory between the instruction-fetch requester and the load/store requester. Data accesses win by default; a bounded starvation counter guarantees fetch progress. The block sits between `core_top`'s fetch and LSU stages and the memory macro. Read responses are routed back to the requester that was granted one cycle earlier.

## Interface

Parameters:

- `STARVE_LIMIT`, default 3. Consecutive cycles a waiting fetch may lose before it is forced a grant. Legal values are 1 to 255.
- `AW`, default 32. Address width.
- `DW`, default 32. Data width.

Ports:

- `clk` in 1: clock; the only clock domain.
- `rst` in 1: synchronous, active-high reset.
- `i_if_req` in 1: fetch request; held until granted.
- `i_if_addr` in AW: fetch address.
- `o_if_gnt` out 1: fetch granted this cycle.
- `o_if_rvalid` out 1: fetch read data valid.
- `o_if_rdata` out DW: fetch read data.
- `i_dm_req` in 1: data request; held until granted.
- `i_dm_addr` in AW: data address.
- `i_dm_wr_type` in 2: 00 = read, 01 = byte write, 10 = halfword write, 11 = word write.
- `i_dm_wdata` in DW: store data.
- `o_dm_gnt` out 1: data granted this cycle.
- `o_dm_rvalid` out 1: load data valid.
- `o_dm_rdata` out DW: load data.
- `o_mem_en` out 1: memory access this cycle.
- `o_mem_addr` out AW: memory address.
- `o_mem_wr_type` out 2: memory write type; 00 means read.
- `o_mem_wdata` out DW: memory write data.
- `i_mem_rdata` in DW: memory read data, valid the cycle after a read access.
- `o_conflict_cnt` out 32: cycles in which both requesters were active.

## Operation

Grant rule, evaluated combinationally each cycle:

- Only `i_dm_req` active: grant data.
- Only `i_if_req` active: grant fetch.
- Both active: grant fetch if `starve_cnt == STARVE_LIMIT`, otherwise grant data.
- Exactly one of `o_if_gnt` / `o_dm_gnt` is high per cycle, or neither if there is no request.

Memory drive:

- `o_mem_en` = `o_if_gnt | o_dm_gnt`.
- Address, write type and write data are muxed from the granted requester.
- A fetch always drives `o_mem_wr_type` = 00.
- When idle, the memory outputs are driven to 0.

Starvation counter `starve_cnt`, width `$clog2(STARVE_LIMIT+1)`:

- Increments on `i_if_req & ~o_if_gnt`.
- Clears on `o_if_gnt`.
- Holds otherwise.
- Never exceeds `STARVE_LIMIT`.

Response routing (registered):

- `rsp_if` <= `o_if_gnt`.
- `rsp_dm` <= `o_dm_gnt & (i_dm_wr_type == 00)`.
- Next cycle: `o_if_rvalid` = `rsp_if`, `o_dm_rvalid` = `rsp_dm`.
- Both `*_rdata` outputs = `i_mem_rdata` when the matching valid is high, else 0.
- Writes produce no response.

Conflict counter:

- `o_conflict_cnt` increments every cycle with `i_if_req & i_dm_req`.
- Saturates at 0xFFFFFFFF.

Reset:

- Clears `starve_cnt`, `rsp_if`, `rsp_dm` and `o_conflict_cnt`.
- All outputs read 0 during reset, including grants, which are gated by `~rst`.
- A grant issued in the cycle before `rst` is asserted yields no rvalid in the reset cycle.

## Timing

- Grant latency is 0 cycles: the grant is combinational from the requests and `starve_cnt`.
- The memory access launches in the grant cycle.
- Read latency is exactly 1 cycle from grant to rvalid. Rvalid is a single-cycle pulse.
- A requester may issue back-to-back requests. This gives one grant per cycle and one response per cycle, in order.
- Handshake rules:
  - A request must hold its address and data stable until granted.
  - Dropping a request before grant is legal; it is simply not served.
- Simultaneous grant and response:
  - A data grant in cycle N overlaps the fetch response for cycle N−1.
  - The two are independent and must not block each other.
- No combinational path from `i_mem_rdata` to any grant or memory output.

## Structure

- Shared package `mem_pkg`:
  - `wr_type_t` with constants `WR_NONE`=00, `WR_B`=01, `WR_H`=10, `WR_W`=11.
  - Requester index enum `REQ_IF`=0, `REQ_DM`=1.
- No sub-module: the grant logic, starvation counter, response registers and perf counter live in one module. Estimated size is about 150 lines.

## Test plan

- Fetch-only stream, addresses 0x0, 0x4, 0x8 on consecutive cycles.
  -> Gnt on each cycle; rvalid one cycle later with the memory word of each address in order; `o_dm_rvalid` stays 0.
- Both requesting continuously, `STARVE_LIMIT`=3.
  -> Grant pattern DM, DM, DM, IF repeating; `starve_cnt` reaches 3, then clears; `o_conflict_cnt` equals the number of cycles.
- Data word write 0xDEADBEEF to 0x100, then a data read of 0x100.
  -> Write gives `o_mem_wr_type`=11 and no rvalid; the read returns `o_dm_rdata`=0xDEADBEEF on the cycle after its grant.
- Data read granted in cycle N while a fetch is pending.
  -> In N+1 the fetch is granted and `o_dm_rvalid`=1 in the same cycle with the correct data; `o_if_rvalid`=1 in N+2.
- `rst` asserted the cycle after a data-read grant.
  -> `o_dm_rvalid`=0, all grants 0, `o_conflict_cnt`=0, `starve_cnt`=0.
- Fetch request dropped after 2 lost cycles, then re-asserted together with a data request.
  -> `starve_cnt` holds at 2 while the fetch is idle; once the fetch re-asserts it loses one more cycle (2→3) and is granted the following cycle.
